// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and instruction-RAM write port of imem_loader.
//   rx_data  [7:0]            incoming byte (source -> loader)
//   rx_valid                  rx_data valid (source -> loader)
//   rx_ready                  loader can take a byte (loader -> source)
//   we                        one-cycle RAM write strobe (loader -> RAM)
//   waddr    [ADDR_WIDTH-1:0] word index of the write (loader -> RAM)
//   wdata    [31:0]           instruction word (loader -> RAM)
// Modports: master = byte source / RAM side, slave = loader side.
interface imem_loader_if #(
    parameter int unsigned ADDR_WIDTH = 8
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [31:0]           wdata;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, we, waddr, wdata
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, we, waddr, wdata
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: receives a framed program image (SYNC, LEN_LO, LEN_HI, 4*LEN
// data bytes, LSB first per word) and writes little-endian 32-bit words into
// the instruction RAM, holding the CPU via cpu_hold while loading.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   bus (slave)    rx_data/rx_valid/rx_ready byte input, we/waddr/wdata RAM write
//   cpu_hold       core reset/stall request
//   load_done      last frame completed successfully
//   load_error     last frame aborted (bad length, timeout, bad checksum)
// Optional: define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum
// byte after the data words.
module imem_loader #(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter bit          HOLD_AT_RESET  = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    imem_loader_if.slave bus,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_error
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, LEN0, LEN1, DATA, WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE, ERR
    } state_t;

    state_t                state;
    logic [TW-1:0]         tmo;
    logic [7:0]            len_lo;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [ADDR_WIDTH-1:0] last_idx;
    logic [1:0]            byte_cnt;
    logic [23:0]           stage;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            csum;
`endif

    logic        accept_c;
    logic        timed_c;
    logic [15:0] len_c;

    assign accept_c = bus.rx_valid && bus.rx_ready;
    assign len_c    = {bus.rx_data, len_lo};
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign timed_c  = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CSUM);
`else
    assign timed_c  = (state == LEN0) || (state == LEN1) || (state == DATA);
`endif

    // Frame FSM with registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            tmo          <= '0;
            len_lo       <= '0;
            word_idx     <= '0;
            last_idx     <= '0;
            byte_cnt     <= '0;
            stage        <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
            bus.rx_ready <= 1'b0;
            bus.we       <= 1'b0;
            bus.waddr    <= '0;
            bus.wdata    <= '0;
            cpu_hold     <= HOLD_AT_RESET;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
        end else begin
            bus.we       <= 1'b0;
            bus.rx_ready <= 1'b1;

            // Inter-byte timeout; an accepted byte in the limit cycle takes priority
            if (timed_c && !accept_c) begin
                if (tmo == TW'(TIMEOUT_CYCLES)) begin
                    state      <= ERR;
                    load_error <= 1'b1;
                end else begin
                    tmo <= tmo + TW'(1);
                end
            end

            case (state)
                IDLE, DONE, ERR: begin
                    if (accept_c && bus.rx_data == SYNC_BYTE) begin
                        state      <= LEN0;
                        tmo        <= '0;
                        cpu_hold   <= 1'b1;
                        load_done  <= 1'b0;
                        load_error <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum       <= '0;
`endif
                    end
                end
                LEN0: begin
                    if (accept_c) begin
                        len_lo <= bus.rx_data;
                        tmo    <= '0;
                        state  <= LEN1;
                    end
                end
                LEN1: begin
                    if (accept_c) begin
                        tmo <= '0;
                        if (len_c == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state     <= CSUM;
`else
                            state     <= DONE;
                            load_done <= 1'b1;
                            cpu_hold  <= 1'b0;
`endif
                        end else if (32'(len_c) > DEPTH) begin
                            state      <= ERR;
                            load_error <= 1'b1;
                        end else begin
                            state    <= DATA;
                            word_idx <= '0;
                            byte_cnt <= '0;
                            last_idx <= ADDR_WIDTH'(len_c - 16'd1);
                        end
                    end
                end
                DATA: begin
                    if (accept_c) begin
                        tmo <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum <= csum ^ bus.rx_data;
`endif
                        if (byte_cnt == 2'd3) begin
                            // Write cycle stalls the sender so no byte is dropped
                            state        <= WRITE;
                            bus.we       <= 1'b1;
                            bus.rx_ready <= 1'b0;
                            bus.waddr    <= word_idx;
                            bus.wdata    <= {bus.rx_data, stage};
                            byte_cnt     <= '0;
                        end else begin
                            case (byte_cnt)
                                2'd0:    stage[7:0]   <= bus.rx_data;
                                2'd1:    stage[15:8]  <= bus.rx_data;
                                default: stage[23:16] <= bus.rx_data;
                            endcase
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end
                WRITE: begin
                    tmo      <= '0;
                    word_idx <= word_idx + ADDR_WIDTH'(1);
                    if (word_idx == last_idx) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state     <= CSUM;
`else
                        state     <= DONE;
                        load_done <= 1'b1;
                        cpu_hold  <= 1'b0;
`endif
                    end else begin
                        state <= DATA;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CSUM: begin
                    if (accept_c) begin
                        if (bus.rx_data == csum) begin
                            state     <= DONE;
                            load_done <= 1'b1;
                            cpu_hold  <= 1'b0;
                        end else begin
                            state      <= ERR;
                            load_error <= 1'b1;
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader.
module tb_imem_loader;

    localparam int unsigned AW   = 8;
    localparam int unsigned TMO  = 40;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    logic cpu_hold, load_done, load_error;

    int nvec = 0;
    int nerr = 0;
    int nwe  = 0;
    logic [7:0] xsum;

    imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

    imem_loader #(
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TMO),
        .SYNC_BYTE      (8'hA5),
        .HOLD_AT_RESET  (1'b1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    // Count write strobes mid-cycle
    always @(negedge clk) if (reset_n && bus.we === 1'b1) nwe++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte is accepted, rx_valid still high
    task automatic send_byte(input logic [7:0] b);
        int n;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        n = 0;
        while (bus.rx_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10) check("rx_ready_timeout", 32'(bus.rx_ready), 32'd1);
        @(negedge clk);
    endtask

    task automatic start_frame(input logic [15:0] len);
        xsum = 8'h00;
        send_byte(8'hA5);
        send_byte(len[7:0]);
        send_byte(len[15:8]);
    endtask

    task automatic send_word(input logic [31:0] w, input logic [7:0] idx, input string tag);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
            xsum = xsum ^ w[8*i +: 8];
        end
        check({tag, "_we"},    32'(bus.we), 32'd1);
        check({tag, "_ready"}, 32'(bus.rx_ready), 32'd0);
        check({tag, "_waddr"}, 32'(bus.waddr), 32'(idx));
        check({tag, "_wdata"}, bus.wdata, w);
    endtask

    task automatic end_frame(input logic [7:0] csum_xor);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(xsum ^ csum_xor);
`endif
        bus.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_status(input string tag, input logic done, input logic err, input logic hold);
        check({tag, "_done"}, 32'(load_done), 32'(done));
        check({tag, "_err"},  32'(load_error), 32'(err));
        check({tag, "_hold"}, 32'(cpu_hold), 32'(hold));
    endtask

    initial begin
        int base;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_ready", 32'(bus.rx_ready), 32'd0);
        check("rst_we",    32'(bus.we), 32'd0);
        check("rst_waddr", 32'(bus.waddr), 32'd0);
        check("rst_wdata", bus.wdata, 32'd0);
        check_status("rst", 1'b0, 1'b0, 1'b1);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(bus.rx_ready), 32'd1);

        // Two-word frame
        base = nwe;
        start_frame(16'd2);
        send_word(32'hFFA1_0293, 8'd0, "a0");
        send_word(32'h0031_8863, 8'd1, "a1");
        end_frame(8'h00);
        check_status("a", 1'b1, 1'b0, 1'b0);
        check("a_nwe", 32'(nwe - base), 32'd2);

        // Garbage then empty frame
        base = nwe;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h12);
        start_frame(16'd0);
        end_frame(8'h00);
        check_status("len0", 1'b1, 1'b0, 1'b0);
        check("len0_nwe", 32'(nwe - base), 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        start_frame(16'd0);
        end_frame(8'h01);
        check_status("badcsum", 1'b0, 1'b1, 1'b1);
`endif

        // Oversize length
        base = nwe;
        start_frame(16'd257);
        bus.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_status("big", 1'b0, 1'b1, 1'b1);
        check("big_nwe", 32'(nwe - base), 32'd0);

        // Inter-byte timeout
        base = nwe;
        start_frame(16'd1);
        send_byte(8'h93);
        send_byte(8'h02);
        bus.rx_valid = 1'b0;
        repeat (TMO - 5) @(negedge clk);
        check("tmo_early_err", 32'(load_error), 32'd0);
        repeat (10) @(negedge clk);
        check_status("tmo", 1'b0, 1'b1, 1'b1);
        check("tmo_nwe", 32'(nwe - base), 32'd0);

        // Recovery, sync value inside data
        start_frame(16'd1);
        send_word(32'h00A5_A5A5, 8'd0, "rec");
        end_frame(8'h00);
        check_status("rec", 1'b1, 1'b0, 1'b0);

        // Full-depth image
        base = nwe;
        start_frame(16'd256);
        for (int i = 0; i < 256; i++)
            send_word(32'h1000_0000 + 32'(i), 8'(i), "full");
        end_frame(8'h00);
        check_status("full", 1'b1, 1'b0, 1'b0);
        check("full_nwe", 32'(nwe - base), 32'd256);

        // Reset mid-frame, then fresh load
        start_frame(16'd2);
        send_word(32'h1122_3344, 8'd0, "mid");
        send_byte(8'h55);
        send_byte(8'h66);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(bus.rx_ready), 32'd0);
        check("mid_rst_we",    32'(bus.we), 32'd0);
        check("mid_rst_waddr", 32'(bus.waddr), 32'd0);
        check("mid_rst_wdata", bus.wdata, 32'd0);
        check_status("mid_rst", 1'b0, 1'b0, 1'b1);
        bus.rx_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        start_frame(16'd1);
        send_word(32'hCAFE_0013, 8'd0, "fresh");
        end_frame(8'h00);
        check_status("fresh", 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
